mem_bus_arbiter: RTL
====================

# mem_bus_arbiter

Two-port arbiter sharing the single external memory bus between the edge cache (read requester, port R) and the path writer (write requester, port W) inside the Dijkstra accelerator. It grants the bus to one requester at a time, forwards that requester's strobes, address and data to memory, and routes the ready/wait_request responses back. It re-arbitrates only at transaction boundaries. Round-robin fairness and a burst cap prevent either requester from starving the other.

## Interface
- MADDR_WIDTH, `DEFAULT_MADDR_WIDTH, memory address width
- MDATA_WIDTH, `DEFAULT_MDATA_WIDTH, memory data width
- MAX_BURST, 16, maximum consecutive completed transactions per grant while the other port is requesting (≥1)
- clock  in  1  single clock, rising edge
- reset  in  1  asynchronous, active-low reset
- r_req  in  1  port R wants the bus (level, held until done)
- r_read  in  1  port R read strobe
- r_addr  in  MADDR_WIDTH  port R address
- r_grant  out  1  port R owns the bus
- r_read_ready  out  1  read data valid for port R
- r_wait_request  out  1  wait_request as seen by port R
- w_req  in  1  port W wants the bus
- w_write  in  1  port W write strobe
- w_addr  in  MADDR_WIDTH  port W address
- w_data  in  MDATA_WIDTH  port W write data
- w_grant  out  1  port W owns the bus
- w_write_ready  out  1  write completed for port W
- w_wait_request  out  1  wait_request as seen by port W
- mem_read_enable, mem_write_enable  out  1  memory strobes
- mem_addr  out  MADDR_WIDTH; mem_write_data  out  MDATA_WIDTH
- mem_read_data  in  MDATA_WIDTH  broadcast unmodified to port R
- mem_read_ready, mem_write_ready, wait_request  in  1  memory responses

## Operation
- States: ARB_IDLE, ARB_READER, ARB_WRITER. Reset state is ARB_IDLE; last_grant resets to W, so R wins the first tie.
- ARB_IDLE: if only one req is high, go to that port's state. If both are high, go to the port that is not last_grant.
- Owned state: mem_read_enable = r_read (ARB_READER only). mem_write_enable = w_write (ARB_WRITER only). mem_addr and mem_write_data are muxed from the owner.
- When no port owns the bus, strobes are 0 and addr/data are 0. Buses are never tri-stated.
- Non-owner strobes are ignored and never forwarded.
- outstanding flag:
  - Set when the owner's strobe is high and wait_request is 0.
  - Cleared on the matching ready (mem_read_ready in ARB_READER, mem_write_ready in ARB_WRITER).
- Completion: the cycle the matching ready is high. burst_cnt increments on each completion and clears on every grant change.
- Release is allowed only on a cycle where outstanding=0 after the update and the owner strobe is 0. Release happens when:
  - the owner has dropped its req, or
  - burst_cnt == MAX_BURST and the other req is high.
- On release, go directly to the other port's state if its req is high, else to ARB_IDLE. Update last_grant to the releasing port.
- Response routing:
  - r_read_ready = mem_read_ready & r_grant.
  - w_write_ready = mem_write_ready & w_grant.
  - x_wait_request = wait_request when granted, else 1.
- burst_cnt saturates at MAX_BURST and is $clog2(MAX_BURST+1) bits.

## Timing
- Outputs at reset: r_grant=0, w_grant=0, mem_read_enable=0, mem_write_enable=0, mem_addr=0, mem_write_data=0, both ready outputs 0, both wait_request outputs 1.
- Grant latency: req sampled high at edge N gives grant high after edge N (one cycle). The requester may assert its strobe in the cycle grant is seen.
- Strobe, address and data forwarding is combinational (zero latency) through the owner mux. Grants are registered.
- Handover: the grant drops after the release edge, and the other grant rises in the same cycle. There are no dead cycles between owners.
- Simultaneous completion and the other port's req rising: completion is counted first, then the release condition is evaluated.
- A req drop while outstanding=1 holds ownership until completion.
- Reset asserted mid-transaction returns all outputs to reset values immediately, asynchronously. The in-flight access is abandoned, and requesters reset with the top level.

## Structure
- Shared package dijkstra_pkg holds:
  - arb_state_t enum {ARB_IDLE, ARB_READER, ARB_WRITER};
  - PORT_R=1'b0, PORT_W=1'b1 constants for last_grant;
  - DEFAULT_MAX_BURST=16.
- One sub-module, mem_arb_rr_pick: combinational 2-way round-robin chooser (inputs r_req, w_req, last_grant; outputs pick_valid, pick_port). It is reused when the cache gains a second read port.
- Everything else (FSM, outstanding flag, burst_cnt, output mux) lives in mem_bus_arbiter.

## Test plan
- Reset then r_req=1 only:
  - r_grant=1 one cycle later.
  - Read of addr 0x40 with wait_request low for 2 cycles: mem_read_enable follows r_read and r_read_ready pulses with mem_read_data=0xDEAD.
- Both reqs high on the same cycle after reset:
  - R is granted first.
  - After R drops req (no outstanding), w_grant=1 on the next cycle with no idle cycle between.
- MAX_BURST=4, R streams reads, w_req rises after R's first completion:
  - R keeps the bus for exactly 4 completions.
  - W is then granted; when W finishes and R still requests, R is regranted.
- W write with wait_request held high 5 cycles and w_req dropped mid-wait:
  - w_grant stays 1 until w_write_ready.
  - Then ARB_IDLE, with mem strobes 0 and mem_addr 0.
- R strobes while W owns the bus: mem_read_enable stays 0 and r_wait_request=1.
- Reset (low) asserted during an outstanding read: all outputs return to reset values within the same cycle. The next grant after release follows the R-first tie rule.

Source files
------------

// File: rtl/dijkstra_pkg.sv
// Shared types and constants for the Dijkstra accelerator memory-side blocks.
package dijkstra_pkg;

   typedef enum logic [1:0] {
      ARB_IDLE   = 2'd0,
      ARB_READER = 2'd1,
      ARB_WRITER = 2'd2
   } arb_state_t;

   // last_grant encoding: the port that most recently released the bus
   localparam logic PORT_R = 1'b0;
   localparam logic PORT_W = 1'b1;

   localparam int DEFAULT_MAX_BURST   = 16;
   localparam int DEFAULT_MADDR_WIDTH = 32;
   localparam int DEFAULT_MDATA_WIDTH = 32;

endpackage

// File: rtl/mem_arb_rr_pick.sv
// Two-way round-robin chooser: a lone requester wins, a tie goes to the port
// that did not hold the bus last.
module mem_arb_rr_pick
   import dijkstra_pkg::*;
(
   input  logic r_req,
   input  logic w_req,
   input  logic last_grant,
   output logic pick_valid,
   output logic pick_port
);

   always_comb begin
      pick_valid = r_req | w_req;
      pick_port  = PORT_R;
      if (r_req && w_req) begin
         pick_port = ~last_grant;
      end else if (w_req) begin
         pick_port = PORT_W;
      end
   end

endmodule

// File: rtl/mem_bus_arbiter.sv
// Shares the external memory bus between the edge cache (R) and the path
// writer (W), re-arbitrating only at transaction boundaries with a burst cap.
module mem_bus_arbiter
   import dijkstra_pkg::*;
#(
   parameter int MADDR_WIDTH = DEFAULT_MADDR_WIDTH,
   parameter int MDATA_WIDTH = DEFAULT_MDATA_WIDTH,
   parameter int MAX_BURST   = DEFAULT_MAX_BURST
) (
   input  logic                   clock,
   input  logic                   reset,
   input  logic                   r_req,
   input  logic                   r_read,
   input  logic [MADDR_WIDTH-1:0] r_addr,
   output logic                   r_grant,
   output logic                   r_read_ready,
   output logic                   r_wait_request,
   output logic [MDATA_WIDTH-1:0] r_read_data,
   input  logic                   w_req,
   input  logic                   w_write,
   input  logic [MADDR_WIDTH-1:0] w_addr,
   input  logic [MDATA_WIDTH-1:0] w_data,
   output logic                   w_grant,
   output logic                   w_write_ready,
   output logic                   w_wait_request,
   output logic                   mem_read_enable,
   output logic                   mem_write_enable,
   output logic [MADDR_WIDTH-1:0] mem_addr,
   output logic [MDATA_WIDTH-1:0] mem_write_data,
   input  logic [MDATA_WIDTH-1:0] mem_read_data,
   input  logic                   mem_read_ready,
   input  logic                   mem_write_ready,
   input  logic                   wait_request
);

   localparam int                BCW         = $clog2(MAX_BURST + 1);
   localparam logic [BCW-1:0]    BURST_LIMIT = BCW'(MAX_BURST);

   arb_state_t     state_q, state_d;
   logic           last_grant_q, last_grant_d;
   logic           outstanding_q, outstanding_d;
   logic [BCW-1:0] burst_cnt_q, burst_cnt_d;

   logic pick_valid;
   logic pick_port;
   logic owner_strobe;
   logic owner_ready;
   logic owner_req;
   logic other_req;
   logic release_ok;

   mem_arb_rr_pick u_rr_pick (
      .r_req      (r_req),
      .w_req      (w_req),
      .last_grant (last_grant_q),
      .pick_valid (pick_valid),
      .pick_port  (pick_port)
   );

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q       <= ARB_IDLE;
         last_grant_q  <= PORT_W;
         outstanding_q <= 1'b0;
         burst_cnt_q   <= '0;
      end else begin
         state_q       <= state_d;
         last_grant_q  <= last_grant_d;
         outstanding_q <= outstanding_d;
         burst_cnt_q   <= burst_cnt_d;
      end
   end

   always_comb begin
      owner_strobe = 1'b0;
      owner_ready  = 1'b0;
      owner_req    = 1'b0;
      other_req    = 1'b0;
      case (state_q)
         ARB_READER: begin
            owner_strobe = r_read;
            owner_ready  = mem_read_ready;
            owner_req    = r_req;
            other_req    = w_req;
         end
         ARB_WRITER: begin
            owner_strobe = w_write;
            owner_ready  = mem_write_ready;
            owner_req    = w_req;
            other_req    = r_req;
         end
         default: ;
      endcase

      // A completing response retires the access even if a strobe is accepted alongside it
      outstanding_d = outstanding_q;
      if (owner_ready) begin
         outstanding_d = 1'b0;
      end else if (owner_strobe && !wait_request) begin
         outstanding_d = 1'b1;
      end

      burst_cnt_d = burst_cnt_q;
      if (owner_ready && (burst_cnt_q != BURST_LIMIT)) begin
         burst_cnt_d = burst_cnt_q + BCW'(1);
      end

      release_ok = !outstanding_d && !owner_strobe &&
                   (!owner_req || ((burst_cnt_d == BURST_LIMIT) && other_req));

      state_d      = state_q;
      last_grant_d = last_grant_q;
      case (state_q)
         ARB_IDLE: begin
            if (pick_valid) begin
               state_d = (pick_port == PORT_R) ? ARB_READER : ARB_WRITER;
            end
         end
         ARB_READER: begin
            if (release_ok) begin
               last_grant_d = PORT_R;
               state_d      = w_req ? ARB_WRITER : ARB_IDLE;
            end
         end
         ARB_WRITER: begin
            if (release_ok) begin
               last_grant_d = PORT_W;
               state_d      = r_req ? ARB_READER : ARB_IDLE;
            end
         end
         default: state_d = ARB_IDLE;
      endcase

      if (state_d != state_q) begin
         burst_cnt_d = '0;
      end
   end

   // Forwarding is purely combinational from the registered owner
   always_comb begin
      r_grant          = (state_q == ARB_READER);
      w_grant          = (state_q == ARB_WRITER);
      mem_read_enable  = (state_q == ARB_READER) & r_read;
      mem_write_enable = (state_q == ARB_WRITER) & w_write;
      mem_addr         = '0;
      mem_write_data   = '0;
      if (state_q == ARB_READER) begin
         mem_addr = r_addr;
      end else if (state_q == ARB_WRITER) begin
         mem_addr       = w_addr;
         mem_write_data = w_data;
      end
      r_read_ready   = mem_read_ready & (state_q == ARB_READER);
      w_write_ready  = mem_write_ready & (state_q == ARB_WRITER);
      r_wait_request = (state_q == ARB_READER) ? wait_request : 1'b1;
      w_wait_request = (state_q == ARB_WRITER) ? wait_request : 1'b1;
      r_read_data    = mem_read_data;
   end

endmodule
